// File: rtl/dmux_stream.sv
// dmux_stream: registered stream demultiplexer.
// Steers each accepted input word to the output channel named by its select field. Every
// channel has a one-entry holding slot, so a stalled channel only blocks words bound for it.
//
// Ports:
//   clock      rising-edge clock
//   reset_n    asynchronous active-low reset
//   in_valid   producer presents a word
//   in_ready   presented word can be accepted this cycle
//   in_data    word to route
//   in_sel     destination channel index
//   out_valid  bit k: channel k slot holds a word
//   out_ready  bit k: consumer k takes the word this cycle
//   out_data   channel k data at bits [k*WIDTH +: WIDTH]
//   xfer_count number of accepted input words since reset (wraps)
module dmux_stream #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned SEL_W   = 1,
  parameter int unsigned COUNT_W = 16
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_data,
  input  logic [SEL_W-1:0]              in_sel,
  output logic [(2**SEL_W)-1:0]         out_valid,
  input  logic [(2**SEL_W)-1:0]         out_ready,
  output logic [(2**SEL_W)*WIDTH-1:0]   out_data,
  output logic [COUNT_W-1:0]            xfer_count
);

  localparam int unsigned N = 2**SEL_W;

  logic [N-1:0]             valid_q, valid_d;
  logic [N-1:0][WIDTH-1:0]  data_q, data_d;
  logic [COUNT_W-1:0]       count_q, count_d;
  logic                     accept;

  // The target slot can take a word if it is empty or is being drained this same cycle.
  assign in_ready = !valid_q[in_sel] || out_ready[in_sel];
  assign accept   = in_valid && in_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    count_d = count_q;
    for (int unsigned k = 0; k < N; k++) begin
      if (valid_q[k] && out_ready[k]) begin
        valid_d[k] = 1'b0;
      end
      // A load wins over a drain: the slot stays full with the new word.
      if (accept && (in_sel == SEL_W'(k))) begin
        valid_d[k] = 1'b1;
        data_d[k]  = in_data;
      end
    end
    if (accept) begin
      count_d = count_q + COUNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_data   = data_q;
  assign xfer_count = count_q;

endmodule

// File: tb/tb_dmux_stream.sv
// Directed bench for dmux_stream. A second instance with a 4-bit counter shares the same
// stimulus so the counter wrap can be observed alongside the default configuration.
module tb_dmux_stream;

  logic        clock;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [0:0]  in_sel;
  logic [1:0]  out_valid;
  logic [1:0]  out_ready;
  logic [31:0] out_data;
  logic [15:0] xfer_count;

  logic        in_ready_w;
  logic [1:0]  out_valid_w;
  logic [31:0] out_data_w;
  logic [3:0]  xfer_count_w;

  int n_vec  = 0;
  int n_fail = 0;
  int exp_count = 0;

  dmux_stream #(.WIDTH(16), .SEL_W(1), .COUNT_W(16)) u_dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .xfer_count (xfer_count)
  );

  dmux_stream #(.WIDTH(16), .SEL_W(1), .COUNT_W(4)) u_dut_w (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready_w),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .out_valid  (out_valid_w),
    .out_ready  (out_ready),
    .out_data   (out_data_w),
    .xfer_count (xfer_count_w)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] d, input logic s);
    in_valid = v;
    in_data  = d;
    in_sel   = s;
  endtask

  task automatic check_count(input string tag);
    logic [15:0] c16;
    logic [3:0]  c4;
    c16 = 16'(exp_count);
    c4  = 4'(exp_count);
    check(tag, 32'(xfer_count), 32'(c16));
    check({tag, "_w"}, 32'(xfer_count_w), 32'(c4));
  endtask

  initial begin
    // Reset with a word presented: nothing may be captured.
    reset_n   = 1'b0;
    out_ready = 2'b00;
    drive(1'b1, 16'h5555, 1'b0);
    #3;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_count", 32'(xfer_count), 32'd0);
    step();
    step();
    check("rst_hold_valid", 32'(out_valid), 32'd0);
    check("rst_hold_data", out_data, 32'd0);
    in_valid = 1'b0;
    reset_n  = 1'b1;
    step();
    step();
    check("idle_valid", 32'(out_valid), 32'd0);
    check_count("idle_count");

    // Basic routing.
    out_ready = 2'b11;
    drive(1'b1, 16'h1234, 1'b0);
    #1;
    check("basic_ready0", 32'(in_ready), 32'd1);
    step();
    exp_count++;
    drive(1'b1, 16'hABCD, 1'b1);
    check("basic_valid0", 32'(out_valid), 32'h1);
    check("basic_data0", 32'(out_data[15:0]), 32'h1234);
    step();
    exp_count++;
    in_valid = 1'b0;
    check("basic_valid1", 32'(out_valid), 32'h2);
    check("basic_data1", 32'(out_data[31:16]), 32'hABCD);
    check_count("basic_count");
    step();
    check("basic_drained", 32'(out_valid), 32'h0);

    // Backpressure on channel 0.
    out_ready = 2'b10;
    drive(1'b1, 16'h0001, 1'b0);
    step();
    exp_count++;
    drive(1'b1, 16'h0002, 1'b0);
    #1;
    check("bp_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_stall_ready", 32'(in_ready), 32'd0);
      check("bp_stall_valid", 32'(out_valid), 32'h1);
      check("bp_stall_data", 32'(out_data[15:0]), 32'h0001);
    end
    check_count("bp_stall_count");
    out_ready = 2'b11;
    #1;
    check("bp_release_ready", 32'(in_ready), 32'd1);
    step();
    exp_count++;
    in_valid = 1'b0;
    check("bp_reload_valid", 32'(out_valid), 32'h1);
    check("bp_reload_data", 32'(out_data[15:0]), 32'h0002);
    check_count("bp_count");
    step();
    check("bp_drained", 32'(out_valid), 32'h0);

    // Stalled channel 0 must not block channel 1.
    out_ready = 2'b10;
    drive(1'b1, 16'h00AA, 1'b0);
    step();
    exp_count++;
    drive(1'b1, 16'h00FF, 1'b1);
    #1;
    check("nb_ready", 32'(in_ready), 32'd1);
    step();
    exp_count++;
    in_valid = 1'b0;
    check("nb_valid", 32'(out_valid), 32'h3);
    check("nb_data1", 32'(out_data[31:16]), 32'h00FF);
    check("nb_data0", 32'(out_data[15:0]), 32'h00AA);
    step();
    check("nb_valid_after", 32'(out_valid), 32'h1);
    check("nb_data0_after", 32'(out_data[15:0]), 32'h00AA);
    out_ready = 2'b11;
    step();
    check("nb_drained", 32'(out_valid), 32'h0);

    // Back-to-back streaming, alternating channel.
    for (int i = 0; i < 8; i++) begin
      logic s;
      s = 1'(i % 2);
      drive(1'b1, 16'(i), s);
      #1;
      check("st_ready", 32'(in_ready), 32'd1);
      step();
      exp_count++;
      check("st_valid", 32'(out_valid), s ? 32'h2 : 32'h1);
      check("st_data", s ? 32'(out_data[31:16]) : 32'(out_data[15:0]), 32'(i));
    end
    in_valid = 1'b0;
    check_count("st_count");
    step();

    // Fill both slots, then reset asynchronously mid-cycle.
    out_ready = 2'b00;
    drive(1'b1, 16'h1111, 1'b0);
    step();
    exp_count++;
    drive(1'b1, 16'h2222, 1'b1);
    step();
    exp_count++;
    in_valid = 1'b0;
    check("mr_full", 32'(out_valid), 32'h3);
    check_count("mr_pre_count");
    #2;
    reset_n = 1'b0;
    #1;
    exp_count = 0;
    check("mr_valid", 32'(out_valid), 32'h0);
    check("mr_valid_w", 32'(out_valid_w), 32'h0);
    check_count("mr_count");
    step();
    reset_n = 1'b1;
    step();
    check("mr_after_valid", 32'(out_valid), 32'h0);

    // Counter wrap: 17 accepts.
    out_ready = 2'b11;
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 16'(16'h0100 + i), 1'(i % 2));
      step();
      exp_count++;
    end
    in_valid = 1'b0;
    check_count("wrap_count");
    check("wrap_small", 32'(xfer_count_w), 32'd1);
    check("wrap_data_w", out_data_w, out_data);
    check("wrap_last", 32'(out_data[15:0]), 32'h0110);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/dmux_stream.md
Name: dmux_stream

Overview:
- Registered stream demultiplexer: the reverse of the word mux. It takes one input word stream and steers each word to one of N output channels.
- The channel is chosen by a per-word select field.
- Valid/ready handshake on the input and on every output. Each output has a one-entry holding register.
- Sits between a single producer (e.g. CPU write path) and multiple consumers (memory/screen/keyboard-side sinks). A stall on one channel does not block words bound for other channels unless the stalled channel's slot is full and the current word targets it.

Parameters:
- WIDTH, 16, data word width in bits.
- SEL_W, 1, select width; number of output channels N = 2**SEL_W.
- COUNT_W, 16, width of the accepted-word counter.

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  producer presents a word.
- in_ready  output  1  block can accept the presented word this cycle.
- in_data  input  WIDTH  word to route.
- in_sel  input  SEL_W  destination channel index.
- out_valid  output  N  bit k: channel k slot holds a word.
- out_ready  input  N  bit k: consumer k takes the word this cycle.
- out_data  output  N*WIDTH  channel k data at bits [k*WIDTH +: WIDTH].
- xfer_count  output  COUNT_W  number of input words accepted since reset.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - out_valid = 0, all out_data = 0, xfer_count = 0.
  - Any word held at assertion is discarded, with no output handshake.
- Per-channel slot k state: EMPTY (out_valid[k]=0) or FULL (out_valid[k]=1).
- Input acceptance:
  - in_ready = !out_valid[in_sel] || out_ready[in_sel].
  - This is combinational from in_sel and out_ready. There are no combinational paths from in_valid or in_data.
  - Accept = in_valid && in_ready.
- Latency: a word accepted in cycle t appears on out_data[in_sel] with out_valid set in cycle t+1.
- Output handshake: slot k drains when out_valid[k] && out_ready[k].
- Slot transitions, per clock edge:
  - EMPTY + accept targeting k -> FULL, data loaded.
  - FULL + drain, no accept targeting k -> EMPTY.
  - FULL + drain + accept targeting k -> stays FULL, new data loaded. Full throughput: one word per cycle per channel.
  - FULL + no drain -> FULL, data unchanged. Accept to k is impossible because in_ready=0.
- Output stability: while out_valid[k] && !out_ready[k], out_data[k] is held constant.
- When a slot empties, out_data[k] retains its last value. Consumers must ignore it while out_valid[k]=0.
- Independence: accept into channel j and drain of channel k≠j in the same cycle both take effect. A full, stalled channel does not block words whose in_sel targets another channel.
- Producer rules:
  - While in_valid && !in_ready, the producer holds in_valid, in_data and in_sel stable.
  - in_valid=0 means no accept, regardless of in_sel.
- xfer_count:
  - Increments by 1 on every accept.
  - Wraps modulo 2**COUNT_W: all-ones + 1 -> 0.
  - Unaffected by output drains.
- No word is ever duplicated, dropped (except by reset), or delivered to a channel other than its in_sel.

Test Plan:
- Reset/idle: hold reset_n=0 with in_valid=1 -> in_ready observed, out_valid=0, xfer_count=0. Release; no stray out_valid without an accept.
- Basic routing (WIDTH=16, SEL_W=1, out_ready=2'b11):
  - Send 16'h1234 sel 0, then 16'hABCD sel 1.
  - Required: out_valid=2'b01 with out_data[15:0]=16'h1234 one cycle after the first accept.
  - Required: out_valid=2'b10 with out_data[31:16]=16'hABCD one cycle after the second accept.
  - xfer_count=2.
- Backpressure/stability:
  - out_ready[0]=0; send 16'h0001 sel 0, then 16'h0002 sel 0.
  - Required: in_ready=0 for the second word and out_data[15:0] holds 16'h0001 for 5 cycles.
  - Raise out_ready[0]: 16'h0001 drains, 16'h0002 is accepted in the same cycle and appears next cycle; xfer_count=2.
- Non-blocking:
  - Channel 0 full and stalled; send 16'h00FF sel 1 with out_ready[1]=1.
  - Required: accepted immediately, delivered on channel 1, channel 0 data unchanged.
- Streaming: 8 back-to-back words 0..7, alternating sel, out_ready=2'b11 -> in_ready stays 1 throughout, each word appears on the correct channel one cycle after its accept, xfer_count=8.
- Reset mid-operation and wrap:
  - Both slots full; assert reset_n=0 asynchronously mid-cycle -> out_valid=0 and xfer_count=0 immediately, before the next edge.
  - With COUNT_W=4, 17 accepts -> xfer_count=1.
